// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit
//
// Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the
// load-use hazard, taken-branch flush, data-memory wait and a software halt
// request into one set of pipeline-register write enables and flush/bubble
// controls. A small FSM handles the memory-wait timeout and an orderly drain
// of the pipeline before halting.
//
// Optional feature macro: PIPE_PERF_EN
//   defined   -> stall_cycles / flush_count are live saturating counters
//   undefined -> both counter ports are tied to zero, no counter flops
//
// Parameters
//   MEM_TIMEOUT   max consecutive memory-wait cycles before error (>=1)
//   DRAIN_CYCLES  NOP-injection cycles after a halt request (>=1)
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   IDEX_memread, IDEX_rt        load in EX and its destination register
//   IFID_rs, IFID_rt             source registers of the instruction in ID
//   branch_taken                 branch/jump resolved taken in EX
//   EXMEM_memaccess, mem_ready   data-memory access in MEM and its completion
//   halt_req                     level-sensitive halt request
//   PCWrite, IFID_write,
//   IDEX_write, EXMEM_write      pipeline register write enables
//   IFID_flush                   load a NOP into IF/ID
//   IDEX_bubble                  zero the ID/EX control fields
//   halted                       pipeline drained and stopped
//   mem_error                    sticky memory timeout flag
//   stall_cycles, flush_count    performance counters
//
// State | meaning
// ------+---------------------------------------------------------------
// RUN   | normal operation, hazards resolved by priority
// DRAIN | halt requested, injecting NOPs until the pipeline is empty
// HALTED| stopped (drain complete or memory timeout), left only by reset

module pipeline_control_unit #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IDEX_memread,
  input  logic [4:0]  IDEX_rt,
  input  logic [4:0]  IFID_rs,
  input  logic [4:0]  IFID_rt,
  input  logic        branch_taken,
  input  logic        EXMEM_memaccess,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        PCWrite,
  output logic        IFID_write,
  output logic        IDEX_write,
  output logic        EXMEM_write,
  output logic        IFID_flush,
  output logic        IDEX_bubble,
  output logic        halted,
  output logic        mem_error,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT) + 1;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t               r_state;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [DRAIN_W-1:0]   r_drain_cnt;
  logic                 r_mem_error;
  logic                 r_halted;

  logic w_memstall;
  logic w_loaduse;
  logic w_timeout;

  assign w_memstall = EXMEM_memaccess && !mem_ready;
  assign w_loaduse  = IDEX_memread && (IDEX_rt != 5'd0) &&
                      ((IDEX_rt == IFID_rs) || (IDEX_rt == IFID_rt));
  assign w_timeout  = w_memstall && (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    PCWrite     = 1'b1;
    IFID_write  = 1'b1;
    IDEX_write  = 1'b1;
    EXMEM_write = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_memstall) begin
          // Freeze everything; branch/load-use are re-evaluated once unfrozen.
          PCWrite     = 1'b0;
          IFID_write  = 1'b0;
          IDEX_write  = 1'b0;
          EXMEM_write = 1'b0;
        end else if (branch_taken) begin
          IFID_flush  = 1'b1;
          IDEX_bubble = 1'b1;
        end else if (w_loaduse) begin
          PCWrite     = 1'b0;
          IFID_write  = 1'b0;
          IDEX_bubble = 1'b1;
        end
      end
      S_DRAIN: begin
        // Fetch is stopped and IF/ID keeps receiving NOPs, so the older
        // instructions flow out; a memory wait still freezes the registers.
        PCWrite    = 1'b0;
        IFID_flush = 1'b1;
        if (w_memstall) begin
          IFID_write  = 1'b0;
          IDEX_write  = 1'b0;
          EXMEM_write = 1'b0;
        end
      end
      default: begin
        PCWrite     = 1'b0;
        IFID_write  = 1'b0;
        IDEX_write  = 1'b0;
        EXMEM_write = 1'b0;
      end
    endcase
  end

  assign halted    = r_halted;
  assign mem_error = r_mem_error;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_drain_cnt <= '0;
      r_mem_error <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      if (r_state != S_HALTED) begin
        if (w_memstall) begin
          if (w_timeout) begin
            r_mem_error <= 1'b1;
            r_halted    <= 1'b1;
            r_state     <= S_HALTED;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end else begin
          r_wait_cnt <= '0;
          if (r_state == S_RUN) begin
            if (halt_req) begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
            end
          end else begin
            if (r_drain_cnt == DRAIN_W'(1)) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
            end
          end
        end
      end
    end
  end

`ifdef PIPE_PERF_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_count;
  logic        w_stall_evt;
  logic        w_flush_evt;

  assign w_stall_evt = (r_state != S_HALTED) && !PCWrite;
  // Only branch-caused flushes count; drain flushes are not mispredicts.
  assign w_flush_evt = (r_state == S_RUN) && !w_memstall && branch_taken;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_flush_evt && (r_flush_count != 16'hFFFF))
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = 16'd0;
  assign flush_count  = 16'd0;
`endif

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the load-use hazard, taken-branch flush, multi-cycle data-memory wait and a software halt request into one consistent set of pipeline-register write enables and flush/bubble controls. A registered state machine handles memory-wait timeout and an orderly pipeline drain before halt. It sits beside the forwarding unit and drives the PC, IF/ID, ID/EX and EX/MEM registers.

## Interface
- MEM_TIMEOUT, 16, max consecutive memory-wait cycles before error (≥1)
- DRAIN_CYCLES, 3, NOP-injection cycles after halt request before `halted` (≥1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- IDEX_memread  in  1  instruction in EX is a load
- IDEX_rt  in  5  load destination register in EX
- IFID_rs, IFID_rt  in  5 each  source registers of instruction in ID
- branch_taken  in  1  branch/jump resolved taken in EX
- EXMEM_memaccess  in  1  instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- halt_req  in  1  halt request (level)
- PCWrite, IFID_write, IDEX_write, EXMEM_write  out  1 each  register write enables
- IFID_flush  out  1  load NOP into IF/ID
- IDEX_bubble  out  1  zero ID/EX control fields
- halted  out  1  pipeline drained and stopped
- mem_error  out  1  sticky memory timeout flag
- stall_cycles, flush_count  out  16 each  performance counters

## Operation
- States: RUN, DRAIN, HALTED. Counters: wait_cnt (timeout), drain_cnt.
- Outputs are combinational from state + inputs; state/counters registered.
- memstall = EXMEM_memaccess && !mem_ready. loaduse = IDEX_memread && IDEX_rt != 0 && (IDEX_rt == IFID_rs || IDEX_rt == IFID_rt).
- Default (RUN, no event): all write enables 1, flush/bubble 0.
- Priority in RUN, highest first:
  - memstall: all four write enables 0, no flush, no bubble (branch/load-use re-evaluated once unfrozen). wait_cnt increments.
  - branch_taken: PCWrite=1 (target), IFID_flush=1, IDEX_bubble=1; load-use ignored.
  - loaduse: PCWrite=0, IFID_write=0, IDEX_bubble=1; IDEX_write, EXMEM_write stay 1.
  - halt_req (no memstall): next state DRAIN, drain_cnt←DRAIN_CYCLES.
- wait_cnt clears whenever memstall is 0. If memstall and wait_cnt == MEM_TIMEOUT-1: mem_error←1, next state HALTED.
- DRAIN: PCWrite=0, IFID_flush=1, IDEX_bubble=0 (branch_taken ignored). memstall freezes as in RUN and holds drain_cnt. Otherwise drain_cnt decrements; at 1 → HALTED. halt_req deasserting does not abort.
- HALTED: all write enables 0, flush/bubble 0, halted=1. Exit only via reset.

## Timing
- Reset (rst_n low at edge): state RUN, counters 0, mem_error 0, halted 0, perf counters 0. Outputs then combinational RUN values.
- Stall/flush responses: zero latency, same cycle as cause.
- halt_req sampled at edge k → DRAIN from k+1. HALTED after DRAIN_CYCLES non-stalled DRAIN cycles.
- Timeout: MEM_TIMEOUT consecutive memstall cycles → HALTED and mem_error the following cycle.
- mem_ready rising with EXMEM_memaccess: no stall that cycle.
- Reset mid-DRAIN or mid-wait returns to RUN, clearing counters and mem_error.

## Configuration
- PIPE_PERF_EN defined: stall_cycles increments each cycle PCWrite==0 in RUN or DRAIN. flush_count increments each cycle IFID_flush==1 caused by branch_taken. Both saturate at 0xFFFF and clear on reset.
- Undefined: both ports driven constant 0, no counter flops.

## Test plan
- Load-use: IDEX_memread=1, IDEX_rt=9, IFID_rs=9 → PCWrite=0, IFID_write=0, IDEX_bubble=1 one cycle. Same with IDEX_rt=0 → no stall.
- Branch plus load-use same cycle: branch_taken=1 → PCWrite=1, IFID_flush=1, IDEX_bubble=1. stall_cycles unchanged, flush_count +1 (PIPE_PERF_EN).
- Memory wait: EXMEM_memaccess=1, mem_ready low 3 cycles, branch_taken=1 → all enables 0 for 3 cycles. Flush appears on cycle 4.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → mem_error=1 and halted=1 from cycle 5. Persists until rst_n=0.
- Drain: halt_req pulse, DRAIN_CYCLES=3, one memstall cycle mid-drain → 4 DRAIN cycles with IFID_flush=1, then halted=1.
- Reset mid-DRAIN: rst_n=0 for one edge → halted=0, write enables 1 next cycle.
